// File: rtl/jump_pkg.sv
// jump_pkg: shared definitions for the jump physics datapath.
//   - VW        : signed vertical-velocity width
//   - KEY_*     : USB HID keycodes recognised by the player
//   - game_state_t : IDLE / RUN / FREEZE encoding of the game_state input
//   - vel_t     : signed vertical velocity type
package jump_pkg;

   localparam int VW = 8;

   localparam logic [7:0] KEY_RIGHT     = 8'd7;
   localparam logic [7:0] KEY_RIGHT_ALT = 8'd79;
   localparam logic [7:0] KEY_LEFT      = 8'd4;
   localparam logic [7:0] KEY_LEFT_ALT  = 8'd80;
   localparam logic [7:0] KEY_FIRE      = 8'd44;

   // 2'b11 is not a member; the datapath treats it like IDLE.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FREEZE = 2'b10
   } game_state_t;

   typedef logic signed [VW-1:0] vel_t;

endpackage

// File: rtl/proj_slot.sv
// proj_slot: one upward-moving projectile channel.
//   frame_clk, Reset       : clock / async active-high reset
//   spawn_i                : load spawn_x_i/spawn_y_i and mark the slot valid
//   advance_i              : frame in which live projectiles move
//   valid_o, x_o, y_o      : registered slot state
module proj_slot
   import jump_pkg::*;
#(
   parameter int PROJ_SPEED = 7
)(
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       spawn_i,
   input  logic [9:0] spawn_x_i,
   input  logic [9:0] spawn_y_i,
   input  logic       advance_i,
   output logic       valid_o,
   output logic [9:0] x_o,
   output logic [9:0] y_o
);

   logic       valid_q, valid_d;
   logic [9:0] x_q, x_d, y_q, y_d;

   always_comb begin
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      // The top only spawns into a slot that is currently empty, so spawn
      // never collides with an in-flight advance.
      if (spawn_i) begin
         valid_d = 1'b1;
         x_d     = spawn_x_i;
         y_d     = spawn_y_i;
      end else if (advance_i && valid_q) begin
         // Leaving the top of the screen: drop the slot, keep the last y.
         if (y_q < 10'(PROJ_SPEED)) valid_d = 1'b0;
         else                       y_d     = y_q - 10'(PROJ_SPEED);
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign valid_o = valid_q;
   assign x_o     = x_q;
   assign y_o     = y_q;

endmodule

// File: rtl/jump_physics_mp.sv
// jump_physics_mp: player physics plus a pool of NUM_PROJ projectiles.
//   frame_clk, Reset   : frame clock / async active-high reset
//   keycode            : HID code (left/right move, fire)
//   game_state         : 00 IDLE, 01 RUN, 10 FREEZE, 11 as IDLE
//   land               : platform contact from the collision block
//   ball_x/y/s, ball_vy: registered player position, size, velocity
//   proj_valid/x/y     : packed per-slot projectile state (10 bits per slot)
//   fire_drop          : one-frame pulse, shot accepted with no free slot
module jump_physics_mp
   import jump_pkg::*;
#(
   parameter int X_MAX         = 639,
   parameter int Y_MAX         = 479,
   parameter int SIZE          = 12,
   parameter int X_CENTER      = 320,
   parameter int Y_START       = 240,
   parameter int JUMP_V        = 12,
   parameter int GRAVITY       = 1,
   parameter int GRAV_DIV      = 4,
   parameter int MAX_FALL      = 10,
   parameter int X_SPEED       = 2,
   parameter int NUM_PROJ      = 4,
   parameter int PROJ_SPEED    = 7,
   parameter int FIRE_COOLDOWN = 8
)(
   input  logic                     frame_clk,
   input  logic                     Reset,
   input  logic [7:0]               keycode,
   input  logic [1:0]               game_state,
   input  logic                     land,
   output logic [9:0]               ball_x,
   output logic [9:0]               ball_y,
   output logic [9:0]               ball_s,
   output logic signed [VW-1:0]     ball_vy,
   output logic [NUM_PROJ-1:0]      proj_valid,
   output logic [NUM_PROJ*10-1:0]   proj_x,
   output logic [NUM_PROJ*10-1:0]   proj_y,
   output logic                     fire_drop
);

   localparam int XW  = 11;
   localparam int YW  = 12;
   localparam int GCW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
   localparam int CDW = $clog2(FIRE_COOLDOWN + 1);
   localparam vel_t VY_JUMP = vel_t'(-JUMP_V);

   game_state_t gs;
   logic        run, frz, advance;

   logic [9:0]     x_q, x_d, y_q, y_d;
   vel_t           vy_q, vy_d, vy_grav;
   logic [GCW-1:0] gc_q, gc_d;
   logic [CDW-1:0] cool_q, cool_d;
   logic           fire_prev_q, drop_q, drop_d;

   logic signed [XW-1:0] dx, x_sum;
   logic signed [YW-1:0] y_sum;
   logic                 key_r, key_l, key_fire;
   logic                 floor_hit, plat_hit, grav_wrap, fire_acc, any_free;
   logic [NUM_PROJ-1:0]  spawn, pv;
   logic [9:0]           spawn_y;

   assign gs      = game_state_t'(game_state);
   assign run     = (gs == RUN);
   assign frz     = (gs == FREEZE);
   assign advance = run || frz;

   assign key_r    = (keycode == KEY_RIGHT) || (keycode == KEY_RIGHT_ALT);
   assign key_l    = (keycode == KEY_LEFT)  || (keycode == KEY_LEFT_ALT);
   assign key_fire = (keycode == KEY_FIRE);

   // Horizontal step in 11-bit signed so one step past either edge is visible.
   always_comb begin
      dx = '0;
      if (key_r && !key_l)      dx = $signed(XW'(X_SPEED));
      else if (key_l && !key_r) dx = -$signed(XW'(X_SPEED));
   end
   assign x_sum = $signed({1'b0, x_q}) + dx;

   // Vertical candidate uses the current velocity, sign-extended.
   assign y_sum     = $signed({2'b00, y_q}) + $signed({{(YW-VW){vy_q[VW-1]}}, vy_q});
   assign floor_hit = (y_sum + $signed(YW'(SIZE)) >= $signed(YW'(Y_MAX))) && !vy_q[VW-1];
   assign plat_hit  = land && !vy_q[VW-1] && (vy_q != '0);
   assign grav_wrap = (gc_q == GCW'(GRAV_DIV - 1));
   // Saturating add so a long fall never wraps the signed velocity.
   assign vy_grav   = (vy_q >= vel_t'(MAX_FALL - GRAVITY)) ? vel_t'(MAX_FALL)
                                                            : vy_q + vel_t'(GRAVITY);

   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      vy_d = vy_q;
      gc_d = gc_q;
      if (run) begin
         if (x_sum > $signed(XW'(X_MAX)))  x_d = 10'(x_sum - $signed(XW'(X_MAX + 1)));
         else if (x_sum < $signed(XW'(0))) x_d = 10'(x_sum + $signed(XW'(X_MAX + 1)));
         else                              x_d = 10'(x_sum);
         gc_d = grav_wrap ? '0 : gc_q + GCW'(1);
         // Floor wins over platform; either bounce suppresses gravity.
         if (floor_hit) begin
            y_d  = 10'(Y_MAX - SIZE);
            vy_d = VY_JUMP;
         end else begin
            y_d = y_sum[9:0];
            if (plat_hit)       vy_d = VY_JUMP;
            else if (grav_wrap) vy_d = vy_grav;
         end
      end
   end

   // Fire is edge-triggered on the key and gated by the cooldown.
   assign fire_acc = run && key_fire && !fire_prev_q && (cool_q == '0);

   // Lowest-index free slot, judged on current valid flags only, so a slot
   // that empties this frame is not reusable until the next one.
   always_comb begin
      spawn    = '0;
      any_free = 1'b0;
      for (int i = 0; i < NUM_PROJ; i++) begin
         if (!pv[i] && !any_free) begin
            spawn[i] = fire_acc;
            any_free = 1'b1;
         end
      end
   end

   always_comb begin
      cool_d = cool_q;
      if (fire_acc)                      cool_d = CDW'(FIRE_COOLDOWN);
      else if (advance && cool_q != '0)  cool_d = cool_q - CDW'(1);
   end

   // A pulse, not held state: it drops back to 0 on any frame without a drop.
   assign drop_d  = fire_acc && !any_free;
   assign spawn_y = y_q - 10'(SIZE);

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         x_q         <= 10'(X_CENTER);
         y_q         <= 10'(Y_START);
         vy_q        <= '0;
         gc_q        <= '0;
         cool_q      <= '0;
         fire_prev_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         vy_q        <= vy_d;
         gc_q        <= gc_d;
         cool_q      <= cool_d;
         fire_prev_q <= key_fire;
         drop_q      <= drop_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_PROJ; i++) begin : g_slot
         proj_slot #(.PROJ_SPEED(PROJ_SPEED)) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .spawn_i   (spawn[i]),
            .spawn_x_i (x_q),
            .spawn_y_i (spawn_y),
            .advance_i (advance),
            .valid_o   (pv[i]),
            .x_o       (proj_x[10*i +: 10]),
            .y_o       (proj_y[10*i +: 10])
         );
      end
   endgenerate

   assign ball_x     = x_q;
   assign ball_y     = y_q;
   assign ball_s     = 10'(SIZE);
   assign ball_vy    = vy_q;
   assign proj_valid = pv;
   assign fire_drop  = drop_q;

endmodule

// File: tb/tb_jump_physics_mp.sv
module tb_jump_physics_mp;
   import jump_pkg::*;

   logic                 frame_clk = 1'b0;
   logic                 Reset;
   logic [7:0]           keycode;
   logic [1:0]           game_state;
   logic                 land;
   logic [9:0]           ball_x, ball_y, ball_s;
   logic signed [VW-1:0] ball_vy;
   logic [3:0]           proj_valid;
   logic [39:0]          proj_x, proj_y;
   logic                 fire_drop;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int rst; int key; int gs; int land; int n;
      int chk_y; int ex; int ey; int evy;
   } vec_t;
   vec_t tbl[$];
   int   spawn_exp[4] = '{455, 345, 260, 200};

   jump_physics_mp dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .game_state (game_state),
      .land       (land),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .ball_s     (ball_s),
      .ball_vy    (ball_vy),
      .proj_valid (proj_valid),
      .proj_x     (proj_x),
      .proj_y     (proj_y),
      .fire_drop  (fire_drop)
   );

   always #5 frame_clk = ~frame_clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic int py(input int i);
      return int'(proj_y[10*i +: 10]);
   endfunction
   function automatic int px(input int i);
      return int'(proj_x[10*i +: 10]);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge frame_clk);
      #1;
   endtask

   // Called between edges; checks the asynchronous effect immediately.
   task automatic do_reset();
      Reset = 1'b1;
      #1;
      chk("rst_x", int'(ball_x), 320);
      chk("rst_y", int'(ball_y), 240);
      chk("rst_vy", int'(ball_vy), 0);
      chk("rst_valid", int'(proj_valid), 0);
      chk("rst_py", int'(proj_y), 0);
      chk("rst_px", int'(proj_x), 0);
      chk("rst_drop", int'(fire_drop), 0);
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; keycode = '0; game_state = 2'b00; land = 1'b0;
      #2;

      // rst key gs land n chk_y x y vy
      tbl.push_back('{1, 0, 1, 0,  4, 1, 320, 240,   1});
      tbl.push_back('{0, 0, 1, 0,  4, 1, 320, 244,   2});
      tbl.push_back('{0, 0, 1, 0, 32, 1, 320, 420,  10});
      tbl.push_back('{0, 0, 1, 0,  4, 1, 320, 460,  10});
      tbl.push_back('{0, 0, 1, 0,  1, 1, 320, 467, -12});
      tbl.push_back('{0, 0, 1, 0,  1, 1, 320, 455, -12});
      tbl.push_back('{0, 0, 1, 0,  2, 1, 320, 431, -11});
      tbl.push_back('{0, 0, 1, 0,  4, 1, 320, 387, -10});
      tbl.push_back('{0, 7, 0, 1, 20, 1, 320, 387, -10});
      tbl.push_back('{0, 0, 1, 0, 28, 1, 320, 191,  -3});
      tbl.push_back('{0, 7, 2, 0, 10, 1, 320, 191,  -3});
      tbl.push_back('{0,79, 1, 1,  1, 1, 322, 188,  -3});
      tbl.push_back('{0, 0, 1, 0, 31, 1, 322, 207,   5});
      tbl.push_back('{0,80, 1, 1,  1, 1, 320, 212, -12});
      tbl.push_back('{0, 7, 3, 1,  5, 1, 320, 212, -12});
      tbl.push_back('{1, 7, 1, 0,159, 0, 638,   0,   0});
      tbl.push_back('{0, 7, 1, 0,  1, 0,   0,   0,   0});
      tbl.push_back('{0, 4, 1, 0,  1, 0, 638,   0,   0});
      tbl.push_back('{0,79, 1, 0,  1, 0,   0,   0,   0});
      tbl.push_back('{0,80, 1, 0,  1, 0, 638,   0,   0});
      tbl.push_back('{0, 0, 1, 0,  1, 0, 638,   0,   0});
      tbl.push_back('{0, 7, 1, 0,  1, 0,   0,   0,   0});
      tbl.push_back('{0, 4, 1, 0,  1, 0, 638,   0,   0});

      foreach (tbl[k]) begin
         if (tbl[k].rst != 0) do_reset();
         keycode    = 8'(tbl[k].key);
         game_state = 2'(tbl[k].gs);
         land       = (tbl[k].land != 0);
         step(tbl[k].n);
         chk($sformatf("row%0d_x", k), int'(ball_x), tbl[k].ex);
         if (tbl[k].chk_y != 0) begin
            chk($sformatf("row%0d_y", k), int'(ball_y), tbl[k].ey);
            chk($sformatf("row%0d_vy", k), int'(ball_vy), tbl[k].evy);
         end
         chk($sformatf("row%0d_valid", k), int'(proj_valid), 0);
      end
      chk("ball_s", int'(ball_s), 12);

      // Four shots fill the pool, the fifth drops.
      do_reset();
      game_state = 2'b01; keycode = 8'd0; land = 1'b0;
      step(45);
      chk("fire_fall_y", int'(ball_y), 467);
      for (int p = 0; p < 5; p++) begin
         keycode = 8'd44;
         step(1);
         if (p < 4) begin
            chk($sformatf("fire%0d_valid", p), int'(proj_valid), (1 << (p + 1)) - 1);
            chk($sformatf("fire%0d_py", p), py(p), spawn_exp[p]);
            chk($sformatf("fire%0d_px", p), px(p), 320);
            chk($sformatf("fire%0d_drop", p), int'(fire_drop), 0);
         end else begin
            chk("drop_pulse", int'(fire_drop), 1);
            chk("drop_valid", int'(proj_valid), 15);
            chk("drop_py0", py(0), 175);
            chk("drop_py1", py(1), 135);
            chk("drop_py2", py(2), 120);
            chk("drop_py3", py(3), 130);
         end
         keycode = 8'd0;
         step(1);
         chk($sformatf("fire%0d_drop_next", p), int'(fire_drop), 0);
         step(8);
      end

      // Held fire key gives a single shot; slot expiry and reuse timing.
      do_reset();
      game_state = 2'b01; keycode = 8'd44;
      step(30);
      chk("hold_valid", int'(proj_valid), 1);
      chk("hold_py0", py(0), 25);
      chk("hold_px0", px(0), 320);
      chk("hold_drop", int'(fire_drop), 0);
      keycode = 8'd0;
      step(1); chk("life_18", py(0), 18);
      step(1); chk("life_11", py(0), 11);
      step(1); chk("life_4", py(0), 4);
      chk("life_4_valid", int'(proj_valid), 1);
      keycode = 8'd44;
      step(1);
      chk("reuse_valid", int'(proj_valid), 2);
      chk("expire_py0", py(0), 4);
      chk("reuse_py1", py(1), 348);
      keycode = 8'd0;
      step(1);
      chk("reuse_py1_next", py(1), 341);
      chk("reuse_valid_next", int'(proj_valid), 2);

      // Reset mid-flight, then IDLE / FREEZE hold and cooldown behaviour.
      do_reset();
      game_state = 2'b01; keycode = 8'd44;
      step(1);
      chk("idle_pre_py0", py(0), 228);
      game_state = 2'b00; keycode = 8'd7; land = 1'b1;
      step(20);
      chk("idle_x", int'(ball_x), 320);
      chk("idle_y", int'(ball_y), 240);
      chk("idle_vy", int'(ball_vy), 0);
      chk("idle_valid", int'(proj_valid), 1);
      chk("idle_py0", py(0), 228);
      chk("idle_drop", int'(fire_drop), 0);
      game_state = 2'b10; keycode = 8'd44; land = 1'b0;
      step(3);
      chk("frz_py0", py(0), 207);
      chk("frz_valid", int'(proj_valid), 1);
      chk("frz_y", int'(ball_y), 240);
      game_state = 2'b01; keycode = 8'd0;
      step(1);
      keycode = 8'd44;
      step(1);
      chk("cool_reject", int'(proj_valid), 1);
      keycode = 8'd0;
      step(3);
      keycode = 8'd44;
      step(1);
      chk("cool_accept", int'(proj_valid), 3);
      chk("cool_py1", py(1), 230);
      chk("cool_py0", py(0), 165);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
